count_readout_sched: RTL and testbench

//  Schedules readout of captured counter words onto the shared SPI serial shifter.
//  Two capture channels (ch0 = gated-count capture, ch1 = second-input capture) each post
//  a word with a 1-cycle strobe. The block holds one word per channel and arbitrates

---
 rtl/count_readout_sched_pkg.sv | 21 ++
 rtl/count_readout_sched_cap_hold_slot.sv | 37 +++
 rtl/count_readout_sched.sv | 124 ++++++++++++
 tb/tb_count_readout_sched.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/count_readout_sched_pkg.sv
// count_readout_sched_pkg: shared FSM states, frame header layout and header builder
package count_readout_sched_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, GAP} state_t;
  localparam int HDR_W = 8;
  localparam int HDR_CH = 7;
  localparam int HDR_SEQ_HI = 6;
  localparam int HDR_SEQ_LO = 3;
  localparam int HDR_OVR = 2;
  localparam int HDR_SYNC_HI = 1;
  localparam int HDR_SYNC_LO = 0;
  localparam logic [1:0] SYNC_MARK = 2'b10;
  function automatic logic [HDR_W-1:0] make_hdr(input logic ch, input logic [3:0] seq, input logic ovr);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_CH] = ch;
    h[HDR_SEQ_HI:HDR_SEQ_LO] = seq;
    h[HDR_OVR] = ovr;
    h[HDR_SYNC_HI:HDR_SYNC_LO] = SYNC_MARK;
    return h;
  endfunction
endpackage

// File: rtl/count_readout_sched_cap_hold_slot.sv
// cap_hold_slot: one-word capture buffer with pending flag, sticky overrun and drop strobe
module cap_hold_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_valid,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             take,
  output logic [WIDTH-1:0] hold,
  output logic             pend,
  output logic             ovr,
  output logic             drop
);
  logic [WIDTH-1:0] hold_q, hold_d;
  logic pend_q, pend_d, ovr_q, ovr_d;
  always_comb begin
    drop = cap_valid & pend_q & ~take;
    hold_d = (cap_valid & (~pend_q | take)) ? cap_data : hold_q;
    pend_d = cap_valid | (pend_q & ~take);
    ovr_d = drop | (ovr_q & ~take);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
    end
  end
  assign hold = hold_q;
  assign pend = pend_q;
  assign ovr = ovr_q;
endmodule

// File: rtl/count_readout_sched.sv
// count_readout_sched: round-robin framing of two capture channels onto a start/done serial shifter
module count_readout_sched
  import count_readout_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             cap_valid,
  input  logic [WIDTH-1:0]       cap_data0,
  input  logic [WIDTH-1:0]       cap_data1,
  output logic                   tx_start,
  output logic [WIDTH+HDR_W-1:0] tx_frame,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   grant_ch,
  output logic [1:0]             ovr_sticky,
  output logic                   timeout_err,
  output logic [7:0]             drop_cnt
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC > GAP_CYC ? TIMEOUT_CYC : GAP_CYC) + 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d, rr_q, rr_d, grant_ch_q, grant_ch_d, timeout_q, timeout_d;
  logic [1:0][3:0] seq_q, seq_d;
  logic [WIDTH+HDR_W-1:0] tx_frame_q, tx_frame_d;
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;
  logic [1:0] take, pend, ovr, drop;
  logic [WIDTH-1:0] cap_d [2];
  logic [WIDTH-1:0] hold [2];
  assign cap_d[0] = cap_data0;
  assign cap_d[1] = cap_data1;
  for (genvar i = 0; i < 2; i++) begin : g_slot
    cap_hold_slot #(.WIDTH(WIDTH)) u_slot (
      .clk(clk),
      .reset(reset),
      .cap_valid(cap_valid[i]),
      .cap_data(cap_d[i]),
      .take(take[i]),
      .hold(hold[i]),
      .pend(pend[i]),
      .ovr(ovr[i]),
      .drop(drop[i])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    rr_d = rr_q;
    seq_d = seq_q;
    tx_frame_d = tx_frame_q;
    grant_ch_d = grant_ch_q;
    timeout_d = timeout_q;
    take = '0;
    drop_sum = {1'b0, drop_q} + 9'(drop[0]) + 9'(drop[1]);
    drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && |pend) begin
          state_d = GRANT;
          sel_d = &pend ? ~rr_q : pend[1];
        end
      end
      GRANT: begin
        take[sel_q] = 1'b1;
        tx_frame_d = {make_hdr(sel_q, seq_q[sel_q], ovr[sel_q]), hold[sel_q]};
        seq_d[sel_q] = seq_q[sel_q] + 4'd1;
        rr_d = sel_q;
        grant_ch_d = sel_q;
        state_d = START;
      end
      START: begin
        cnt_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done in the final timer cycle still counts as a clean completion
        if (tx_done || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = timeout_q | ~tx_done;
          cnt_d = '0;
          state_d = GAP;
        end
      end
      GAP: state_d = (cnt_q == CNT_W'(GAP_CYC - 1)) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= 1'b0;
      rr_q <= 1'b1;
      seq_q <= '0;
      tx_frame_q <= '0;
      grant_ch_q <= 1'b0;
      timeout_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      seq_q <= seq_d;
      tx_frame_q <= tx_frame_d;
      grant_ch_q <= grant_ch_d;
      timeout_q <= timeout_d;
      drop_q <= drop_d;
    end
  end
  assign tx_start = state_q == START;
  assign busy = state_q != IDLE;
  assign tx_frame = tx_frame_q;
  assign grant_ch = grant_ch_q;
  assign ovr_sticky = ovr;
  assign timeout_err = timeout_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_count_readout_sched.sv
// tb_count_readout_sched: scripted + random captures against a transaction-timing reference model
module tb_count_readout_sched;
  localparam int W = 32, GAP = 5, TO = 40, INF = 1 << 30, NCYC = 6000;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, tx_done = 1'b0;
  logic [1:0] cap_valid = '0;
  logic [W-1:0] cap_data0 = '0, cap_data1 = '0;
  logic tx_start, busy, grant_ch, timeout_err;
  logic [W+7:0] tx_frame;
  logic [1:0] ovr_sticky;
  logic [7:0] drop_cnt;
  always #5 clk = ~clk;
  count_readout_sched #(.WIDTH(W), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .cap_valid(cap_valid),
    .cap_data0(cap_data0), .cap_data1(cap_data1), .tx_start(tx_start),
    .tx_frame(tx_frame), .tx_done(tx_done), .busy(busy), .grant_ch(grant_ch),
    .ovr_sticky(ovr_sticky), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );
  typedef struct {logic [W+7:0] frame; logic ch; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  logic m_pend[2], m_ovr[2], m_rr, m_to, m_ch, chk = 1'b0;
  logic [W-1:0] m_word[2];
  int m_seq[2], m_drops, idle_at, g_at, done_at, to_at, wait_lo, wait_hi, cur;
  logic s_busy, s_to;
  logic [1:0] s_ovr;
  logic [7:0] s_drop;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cur, act, exp);
    end
  endtask
  task automatic model_reset(input int k);
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_ovr[i] = 0; m_word[i] = '0; m_seq[i] = 0;
    end
    m_rr = 1; m_ch = 0; m_drops = 0; m_to = 0;
    idle_at = k + 1; g_at = INF; done_at = INF; to_at = INF; wait_lo = INF; wait_hi = -1;
    while (q.size() > 0 && q[$].cyc > k) void'(q.pop_back());
  endtask
  always @(negedge clk) if (chk) begin
    check("busy", busy, s_busy);
    check("drop_cnt", drop_cnt, s_drop);
    check("ovr_sticky", ovr_sticky, s_ovr);
    check("timeout_err", timeout_err, s_to);
    if (cur == 0) begin
      check("reset_tx_frame", tx_frame, 0);
      check("reset_grant_ch", grant_ch, 0);
      check("reset_tx_start", tx_start, 0);
    end
    if (cur == 5) check("t1_frame", tx_frame, 40'h02_0000_3039);
    if (cur == 421 || cur == 422) check("t5_start_after_en", tx_start, cur == 422);
    if (q.size() > 0 && q[0].cyc < cur) begin
      check("tx_start_missing", cur, q[0].cyc);
      void'(q.pop_front());
    end
    if (tx_start) begin
      if (q.size() == 0) check("frames_pending", q.size(), 1);
      else begin
        e = q.pop_front();
        check("tx_frame", tx_frame, e.frame);
        check("grant_ch", grant_ch, e.ch);
        check("tx_start_cycle", cur, e.cyc);
      end
    end
  end
  initial begin
    logic rst_k, en_k, done_k, dec, ch_new, take;
    logic [1:0] cv;
    logic [W-1:0] dv[2];
    int d, ws;
    en_k = 1;
    repeat (3) @(posedge clk);
    #1;
    model_reset(-1);
    chk = 1;
    for (int k = 0; k < NCYC; k++) begin
      cur = k;
      if (k >= to_at) begin m_to = 1; to_at = INF; end
      s_busy = k < idle_at;
      s_drop = 8'(m_drops);
      s_ovr = {m_ovr[1], m_ovr[0]};
      s_to = m_to;
      rst_k = 0; cv = '0; dv[0] = $urandom; dv[1] = $urandom;
      if (k < 500) begin
        en_k = !(k >= 300 && k < 420);
        case (k)
          2: begin cv = 2'b01; dv[0] = 32'h0000_3039; end
          40: cv = 2'b11;
          100, 104, 106, 450: cv = 2'b01;
          200, 305, 470: cv = 2'b10;
          458: rst_k = 1;
          default: ;
        endcase
      end else if (k < NCYC - 150) begin
        if ($urandom_range(0, 99) == 0) en_k = !en_k;
        cv = {$urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0};
        rst_k = $urandom_range(0, 999) == 0;
      end else en_k = 1;
      done_k = (k == done_at) || (k == wait_lo - 1 && $urandom_range(0, 1) == 0) ||
               ((k < wait_lo || k > wait_hi) && $urandom_range(0, 29) == 0);
      reset = rst_k; en = en_k; cap_valid = cv; cap_data0 = dv[0]; cap_data1 = dv[1]; tx_done = done_k;
      if (rst_k) model_reset(k);
      else begin
        dec = k >= idle_at && en_k && (m_pend[0] || m_pend[1]);
        ch_new = (m_pend[0] && m_pend[1]) ? !m_rr : m_pend[1];
        for (int i = 0; i < 2; i++) begin
          take = (k == g_at) && (int'(m_ch) == i);
          if (take) begin
            q.push_back('{{8'(i * 128 + m_seq[i] * 8 + (m_ovr[i] ? 4 : 0) + 2), m_word[i]}, 1'(i), k + 1});
            m_seq[i] = (m_seq[i] + 1) % 16;
            m_rr = 1'(i);
          end
          if (cv[i] && m_pend[i] && !take) begin m_ovr[i] = 1; m_drops++; end
          else if (cv[i]) begin m_word[i] = dv[i]; m_pend[i] = 1; if (take) m_ovr[i] = 0; end
          else if (take) begin m_pend[i] = 0; m_ovr[i] = 0; end
        end
        if (m_drops > 255) m_drops = 255;
        if (dec) begin
          m_ch = ch_new; g_at = k + 1; ws = k + 3; wait_lo = ws;
          if (k < 500) d = (k >= 195 && k < 260) ? TO : (k >= 440 && k < 460) ? 30 : 5;
          else case ($urandom_range(0, 9))
            0: d = TO;
            1: d = TO - 1;
            2: d = 0;
            default: d = $urandom_range(1, 12);
          endcase
          if (d < TO) begin
            done_at = ws + d; wait_hi = ws + d; idle_at = ws + d + 1 + GAP;
          end else begin
            done_at = INF; wait_hi = ws + TO - 1; to_at = ws + TO; idle_at = ws + TO + GAP;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    chk = 0;
    check("frames_outstanding", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
